hevc_luma_interp_stream: RTL and testbench

- Streaming HEVC luma fractional-sample interpolator with a parametrised bit depth.
- Accepts one integer pixel per beat of a row and builds its own 8-tap sliding window.
- Emits one sub-pixel per beat for a phase selected per row: full, quarter, half or three-quarter.
- Replaces the fixed per-phase filters; valid/ready on both sides so it can chain horizontal-then-vertical passes.

---
 rtl/hevc_luma_interp_stream.sv | 146 ++++++++++++++
 tb/tb_hevc_luma_interp_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hevc_luma_interp_stream.sv
// HEVC luma fractional-sample interpolator, streaming one pixel per beat.
// Builds its own 8-tap window; three-stage pipeline with valid/ready on both sides.
module hevc_luma_interp_stream #(
  parameter int BIT_DEPTH = 8,
  parameter int ROW_LEN   = 64,
  parameter int CNT_W     = 7
) (
  input  logic                 clock,
  input  logic                 reset_L,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_DEPTH-1:0] in_pixel,
  input  logic                 in_row_start,
  input  logic [1:0]           in_frac,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_DEPTH-1:0] out_pixel,
  output logic                 out_last,
  output logic                 err_overrun
);

  localparam int SW = BIT_DEPTH + 8;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(ROW_LEN);
  localparam logic [CNT_W-1:0] FIRST = CNT_W'(8);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << BIT_DEPTH) - 1);

  localparam logic signed [7:0] CQ [8] =
    '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam logic signed [7:0] CH [8] =
    '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam logic signed [7:0] CT [8] =
    '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};

  logic [BIT_DEPTH-1:0] win [8];
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cntNext;
  logic [1:0]           frac;

  logic stall;
  logic accept;
  logic drop;
  logic take;
  logic launch;

  logic       s1Valid;
  logic       s1Last;
  logic [1:0] s1Frac;

  logic                 s2Valid;
  logic                 s2Last;
  logic signed [SW-1:0] s2Sum;

  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] coef;
  logic signed [SW-1:0] pix;
  logic signed [SW-1:0] rnd;
  logic [BIT_DEPTH-1:0] clip;

  always_comb begin
    stall    = out_valid && !out_ready;
    in_ready = !stall;
    accept   = in_valid && in_ready;
    drop     = accept && !in_row_start
               && (cnt == '0 || cnt == FULL);
    take     = accept && !drop;
    cntNext  = in_row_start ? CNT_W'(1)
                            : cnt + CNT_W'(1);
    launch   = take && (cntNext >= FIRST);
  end

  // S1: window, row counter and launch tag
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 8; i++) win[i] <= '0;
      cnt         <= '0;
      frac        <= '0;
      err_overrun <= 1'b0;
      s1Valid     <= 1'b0;
      s1Last      <= 1'b0;
      s1Frac      <= '0;
    end else begin
      if (take) begin
        for (int i = 0; i < 7; i++) win[i] <= win[i+1];
        win[7] <= in_pixel;
        cnt    <= cntNext;
        if (in_row_start) frac <= in_frac;
      end
      if (drop) err_overrun <= 1'b1;
      if (!stall) begin
        s1Valid <= launch;
        s1Last  <= launch && (cntNext == FULL);
        s1Frac  <= frac;
      end
    end
  end

  always_comb begin
    acc  = '0;
    coef = '0;
    pix  = '0;
    for (int i = 0; i < 8; i++) begin
      unique case (s1Frac)
        2'd1:    coef = SW'(CQ[i]);
        2'd2:    coef = SW'(CH[i]);
        2'd3:    coef = SW'(CT[i]);
        default: coef = '0;
      endcase
      pix = SW'({1'b0, win[i]});
      acc = acc + coef * pix;
    end
    // full phase: pre-scale so the shared rounding returns w[3]
    if (s1Frac == 2'd0) acc = SW'({1'b0, win[3], 6'b0});
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      s2Valid <= 1'b0;
      s2Last  <= 1'b0;
      s2Sum   <= '0;
    end else if (!stall) begin
      s2Valid <= s1Valid;
      s2Last  <= s1Last;
      s2Sum   <= acc;
    end
  end

  always_comb begin
    rnd = (s2Sum + SW'(32)) >>> 6;
    if (rnd < 0)         clip = '0;
    else if (rnd > MAXV) clip = '1;
    else                 clip = rnd[BIT_DEPTH-1:0];
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2Valid;
      out_last  <= s2Valid && s2Last;
      if (s2Valid) out_pixel <= clip;
    end
  end

endmodule

// File: tb/tb_hevc_luma_interp_stream.sv
// Directed bench for hevc_luma_interp_stream, 8-bit, 16-pixel rows.
// Outputs are collected on handshakes and compared against hand values.
module tb_hevc_luma_interp_stream;

  localparam int BD = 8;
  localparam int RL = 16;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pixel = '0;
  logic       in_row_start = 1'b0;
  logic [1:0] in_frac = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_pixel;
  logic       out_last;
  logic       err_overrun;

  int nAsserts = 0;
  int nFail = 0;

  int rowPix [RL];
  int win8 [8];
  int cQ [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  int cH [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  int cT [8] = '{0, 1, -5, 17, 58, -10, 4, -1};

  logic [7:0] qPix [$];
  logic       qLast [$];
  logic [7:0] held;

  hevc_luma_interp_stream #(
    .BIT_DEPTH(BD),
    .ROW_LEN(RL),
    .CNT_W(5)
  ) dut (
    .clock(clock),
    .reset_L(reset_L),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pixel(in_pixel),
    .in_row_start(in_row_start),
    .in_frac(in_frac),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .out_last(out_last),
    .err_overrun(err_overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_L && out_valid && out_ready) begin
      qPix.push_back(out_pixel);
      qLast.push_back(out_last);
    end
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // called just after a rising edge; returns just after the accept edge
  task automatic send(logic [7:0] p, logic rs, logic [1:0] f);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_pixel = p;
    in_row_start = rs;
    in_frac = f;
    @(negedge clock);
    while (!in_ready && t < 40) begin
      t++;
      @(negedge clock);
    end
    if (t >= 40) chk("send_timeout", in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_row_start = 1'b0;
  endtask

  function automatic int golden(int f, int k);
    int s;
    int r;
    int c;
    if (f == 0) return rowPix[k+3];
    s = 0;
    for (int i = 0; i < 8; i++) begin
      c = (f == 1) ? cQ[i] : (f == 2) ? cH[i] : cT[i];
      s += c * rowPix[k+i];
    end
    r = (s + 32) >>> 6;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic settle();
    repeat (8) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic sendRow(int f);
    for (int i = 0; i < RL; i++)
      send(8'(rowPix[i]), i == 0, 2'(f));
  endtask

  task automatic checkRow(string tag, int f);
    settle();
    chk({tag, "_count"}, qPix.size(), RL - 7);
    for (int k = 0; k < RL - 7; k++) begin
      if (k < qPix.size()) begin
        chk($sformatf("%s_px%0d", tag, k),
            qPix[k], golden(f, k));
        chk($sformatf("%s_last%0d", tag, k),
            qLast[k], k == RL - 8);
      end
    end
    qPix.delete();
    qLast.delete();
  endtask

  task automatic winTest(string tag, int f, int exp);
    for (int i = 0; i < 8; i++)
      send(8'(win8[i]), i == 0, 2'(f));
    settle();
    chk({tag, "_count"}, qPix.size(), 1);
    if (qPix.size() > 0) begin
      chk({tag, "_px"}, qPix[0], exp);
      chk({tag, "_last"}, qLast[0], 0);
    end
    qPix.delete();
    qLast.delete();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_pixel", out_pixel, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", err_overrun, 0);
    chk("rst_ready", in_ready, 1);
    reset_L = 1'b1;
    @(posedge clock);
    #1;

    // flat row: latency of first output, then the whole row
    for (int i = 0; i < RL; i++) rowPix[i] = 100;
    for (int i = 0; i < 8; i++) send(8'd100, i == 0, 2'd2);
    @(negedge clock);
    chk("lat_e0", out_valid, 0);
    @(negedge clock);
    chk("lat_e1", out_valid, 0);
    @(negedge clock);
    chk("lat_e2", out_valid, 1);
    chk("lat_px", out_pixel, 100);
    @(posedge clock);
    #1;
    for (int i = 8; i < RL; i++) send(8'd100, 1'b0, 2'd2);
    checkRow("flat", 2);

    win8 = '{0, 0, 0, 0, 255, 255, 255, 255};
    winTest("step_half", 2, 128);
    winTest("step_qtr", 1, 52);
    // sum 13005 -> floor(13037/64)
    winTest("step_3qtr", 3, 203);
    winTest("step_full", 0, 0);
    win8 = '{0, 0, 0, 255, 255, 0, 0, 0};
    winTest("clip_hi", 2, 255);
    win8 = '{0, 0, 255, 0, 0, 255, 0, 0};
    winTest("clip_lo", 2, 0);

    // back-pressure for 5 cycles mid-row
    rowPix = '{10, 200, 30, 250, 0, 128, 77, 255,
               5, 90, 180, 60, 220, 15, 140, 99};
    for (int i = 0; i < RL; i++) begin
      send(8'(rowPix[i]), i == 0, 2'd3);
      if (i == 9) begin
        out_ready = 1'b0;
        @(negedge clock);
        chk("stall_ready0", in_ready, 0);
        chk("stall_valid", out_valid, 1);
        held = out_pixel;
        repeat (4) begin
          @(negedge clock);
          chk("stall_ready", in_ready, 0);
          chk("stall_hold", out_pixel, held);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    end
    checkRow("stall", 3);
    chk("stall_err", err_overrun, 0);

    // 17th pixel without row start
    send(8'd77, 1'b0, 2'd3);
    settle();
    chk("ovr_no_out", qPix.size(), 0);
    chk("ovr_err", err_overrun, 1);
    for (int i = 0; i < RL; i++) rowPix[i] = i * 16 + 3;
    sendRow(2);
    checkRow("after_ovr", 2);
    chk("ovr_sticky", err_overrun, 1);

    // reset with three outputs held in the pipe
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      send(8'(rowPix[i]), i == 0, 2'd1);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_err", err_overrun, 0);
    chk("mid_rst_pixel", out_pixel, 0);
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset_L = 1'b1;
    @(posedge clock);
    #1;
    settle();
    chk("rst_no_emit", qPix.size(), 0);
    rowPix = '{255, 0, 255, 0, 12, 34, 56, 78,
               90, 123, 210, 3, 64, 64, 200, 1};
    sendRow(1);
    checkRow("post_rst", 1);

    // pixel with no open row
    send(8'd5, 1'b0, 2'd0);
    send(8'd6, 1'b0, 2'd0);
    send(8'd7, 1'b0, 2'd0);
    send(8'd8, 1'b0, 2'd0);
    settle();
    chk("norow_err", err_overrun, 1);
    chk("norow_no_out", qPix.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFail);
    $finish;
  end

endmodule
